datapath_param: RTL and testbench
=================================

# datapath_param

Parametrised bus-based CPU datapath: general register file, PC, HI/LO, MDR, Y and Z (ZHI/ZLO) registers around a single shared bus, plus an ALU with a sequential signed multiply/divide unit. It succeeds the fixed 32-bit, 16-register, one-enable-per-register datapath: registers are index-addressed, width and register count are parameters, and ALU operations are launched with a start/busy/done handshake. It sits between the control unit (which drives all enables, indices and op) and memory (via MDR).

## Interface
- `WIDTH`, 32: datapath width (even, ≥8).
- `NREGS`, 16: general registers; index width `IW = $clog2(NREGS)`.
- `clk` in 1: sole clock, rising edge.
- `clr` in 1: synchronous, active-high reset.
- `mdatain` in WIDTH: memory read data.
- `readMDR` in 1: MDR source select, 1 = `mdatain`, 0 = bus.
- `MDRin` in 1: MDR load enable.
- `reg_in_en` / `reg_in_idx` in 1 / IW: write bus into R[idx].
- `reg_out_en` / `reg_out_idx` in 1 / IW: drive R[idx] onto bus.
- `Yin`, `PCin`, `HIin`, `LOin` in 1: load bus into Y, PC, HI, LO.
- `HIout`, `LOout`, `ZHIout`, `ZLOout`, `PCout`, `MDRout` in 1: bus source enables.
- `op` in 4: ALU operation.
- `start` in 1: launch ALU op (sampled only when idle).
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle pulse, Z updated.
- `busMuxOut` out WIDTH: bus value.
- `PC`, `MDR`, `HI`, `LO`, `Y`, `ZHI`, `ZLO` out WIDTH: register contents.
- `rf_dbg` out WIDTH*NREGS: flat register file, R0 at LSBs.

## Operation
- Bus: combinational, fixed priority reg_out_en > HIout > LOout > ZHIout > ZLOout > PCout > MDRout; none asserted → 0.
- All loads on rising `clk` from current bus value; simultaneous loads to several targets allowed. MDR loads `readMDR ? mdatain : busMuxOut` when `MDRin`.
- ALU operands: A = Y, B = bus, captured at the start edge. Ops: 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 NOT B; 5 NEG −B; 6 SHL A<<s; 7 SHR logical; 8 SHRA arithmetic; 9 ROL; 10 ROR (s = B[log2(WIDTH)−1:0]); 11 MUL; 12 DIV; 13–15 undefined → ZLO=0.
- Single-cycle ops (0–10, 13–15): ZLO ← result, ZHI ← 0 at start edge.
- MUL: signed, WIDTH iterations of shift-add on magnitudes, then sign fix; {ZHI,ZLO} ← 2·WIDTH product.
- DIV: signed restoring division on magnitudes; ZLO ← quotient (truncated toward zero), ZHI ← remainder (sign of dividend A). B=0: ZLO ← all ones, ZHI ← A, same latency.
- FSM: IDLE → (start & op∈{MUL,DIV}) → ITER (counter WIDTH−1 down to 0, one iteration per cycle) → FIX → IDLE. FIX edge writes Z and sets done.
- `start` while busy ignored; op/Y/bus may change freely during ITER. Register file, PC, HI, LO, MDR, Y loads and bus continue normally while busy.

## Timing
- Reset: all registers, Y, Z, PC, HI, LO, MDR = 0; FSM IDLE; busy=0; done=0. `clr` dominates every load and start in the same cycle.
- Single-cycle op: Z and done valid the cycle after the start edge; busy stays 0.
- MUL/DIV: busy high for WIDTH+1 cycles after the start edge (WIDTH ITER + 1 FIX); Z valid and done high the cycle after the FIX edge (WIDTH+1 edges after start); busy low in that cycle. Back-to-back start is accepted in the done cycle.
- `clr` mid-op: next cycle IDLE, busy=0, Z=0, no done pulse.
- Bus-to-register path is single-cycle combinational; no bus pipelining.

## Configuration
- `DATAPATH_MULDIV_EN` defined: MUL/DIV sequencer present as above.
- Undefined: no sequencer; ops 11/12 behave as undefined single-cycle ops (ZLO=0, ZHI=0, done next cycle), busy tied 0.

## Test plan
- clr; mdatain=0x00000012, readMDR=1, MDRin=1; then MDRout, reg_in_en, idx=3 → R3=0x00000012, bus=0x12 during transfer.
- Y=5, bus=7, op=ADD, start → next cycle ZLO=12, ZHI=0, done=1 for one cycle, busy never 1.
- Y=0x80000000, bus=4, op=SHRA → ZLO=0xF8000000; op=ROR, Y=0x00000001, bus=1 → ZLO=0x80000000.
- Y=0xFFFFFFFD (−3), bus=7, op=MUL → busy 33 cycles, then ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB, done pulse.
- Y=−7, bus=2, op=DIV → ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF; Y=9, bus=0 → ZLO=0xFFFFFFFF, ZHI=9.
- MUL started, clr at cycle 10 → busy=0, ZHI=ZLO=0 next cycle, no done; start asserted while busy → ignored, Z unchanged.

Source files
------------

// File: rtl/datapath_param.sv
// datapath_param: bus-based CPU datapath. It has an index-addressed register file, PC, HI, LO,
// MDR, Y and Z (ZHI/ZLO) registers around one shared bus. The ALU takes A = Y and B = bus.
// Optional feature macro: DATAPATH_MULDIV_EN. When it is defined, a sequential signed
// multiply/divide unit is added, with a start/busy/done handshake.
module datapath_param #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         mdatain,
    input  logic                     readMDR,
    input  logic                     MDRin,
    input  logic                     reg_in_en,
    input  logic [$clog2(NREGS)-1:0] reg_in_idx,
    input  logic                     reg_out_en,
    input  logic [$clog2(NREGS)-1:0] reg_out_idx,
    input  logic                     Yin,
    input  logic                     PCin,
    input  logic                     HIin,
    input  logic                     LOin,
    input  logic                     HIout,
    input  logic                     LOout,
    input  logic                     ZHIout,
    input  logic                     ZLOout,
    input  logic                     PCout,
    input  logic                     MDRout,
    input  logic [3:0]               op,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         busMuxOut,
    output logic [WIDTH-1:0]         PC,
    output logic [WIDTH-1:0]         MDR,
    output logic [WIDTH-1:0]         HI,
    output logic [WIDTH-1:0]         LO,
    output logic [WIDTH-1:0]         Y,
    output logic [WIDTH-1:0]         ZHI,
    output logic [WIDTH-1:0]         ZLO,
    output logic [WIDTH*NREGS-1:0]   rf_dbg
);

    localparam int unsigned IW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SHRA = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;

    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] rf_sel;
    logic [WIDTH-1:0] alu_res;
    logic [SW-1:0]    shamt;
    logic             single_go;

    // Flat debug view of the register file, R0 in the LSBs
    for (genvar g = 0; g < NREGS; g++) begin : g_dbg
        assign rf_dbg[g*WIDTH +: WIDTH] = rf[g];
    end

    // Register file read port
    always_comb begin
        rf_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_out_idx == IW'(i)) rf_sel = rf[i];
        end
    end

    // Shared bus, fixed priority with the register file first
    always_comb begin
        if (reg_out_en)  busMuxOut = rf_sel;
        else if (HIout)  busMuxOut = HI;
        else if (LOout)  busMuxOut = LO;
        else if (ZHIout) busMuxOut = ZHI;
        else if (ZLOout) busMuxOut = ZLO;
        else if (PCout)  busMuxOut = PC;
        else if (MDRout) busMuxOut = MDR;
        else             busMuxOut = '0;
    end

    // Register file write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (clr) rf[i] <= '0;
            else if (reg_in_en && reg_in_idx == IW'(i)) rf[i] <= busMuxOut;
        end
    end

    // Special registers loaded from the bus (MDR may instead load memory data)
    always_ff @(posedge clk) begin
        if (clr) begin
            PC  <= '0;
            HI  <= '0;
            LO  <= '0;
            Y   <= '0;
            MDR <= '0;
        end else begin
            if (PCin)  PC  <= busMuxOut;
            if (HIin)  HI  <= busMuxOut;
            if (LOin)  LO  <= busMuxOut;
            if (Yin)   Y   <= busMuxOut;
            if (MDRin) MDR <= readMDR ? mdatain : busMuxOut;
        end
    end

    assign shamt = busMuxOut[SW-1:0];

    // Single-cycle ALU; a shift by zero makes the complementary rotate term vanish
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = Y + busMuxOut;
            OP_SUB:  alu_res = Y - busMuxOut;
            OP_AND:  alu_res = Y & busMuxOut;
            OP_OR:   alu_res = Y | busMuxOut;
            OP_NOT:  alu_res = ~busMuxOut;
            OP_NEG:  alu_res = -busMuxOut;
            OP_SHL:  alu_res = Y << shamt;
            OP_SHR:  alu_res = Y >> shamt;
            OP_SHRA: alu_res = $signed(Y) >>> shamt;
            OP_ROL:  alu_res = (Y << shamt) | (Y >> (WIDTH - 32'(shamt)));
            OP_ROR:  alu_res = (Y >> shamt) | (Y << (WIDTH - 32'(shamt)));
            default: alu_res = '0;
        endcase
    end

`ifdef DATAPATH_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t             state, state_n;
    logic               is_seq_op, seq_go;
    logic               is_div, neg_q;
    logic [WIDTH-1:0]   a_q, m, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [SW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]   fix_hi, fix_lo, quo, rem;

    assign is_seq_op = (op == OP_MUL) || (op == OP_DIV);
    assign seq_go    = start && (state == S_IDLE) && is_seq_op;
    assign single_go = start && (state == S_IDLE) && !is_seq_op;
    assign mag_a     = Y[WIDTH-1] ? -Y : Y;
    assign mag_b     = busMuxOut[WIDTH-1] ? -busMuxOut : busMuxOut;

    // Sequencer state register; busy mirrors the next state
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != S_IDLE);
        end
    end

    // Sequencer next state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (seq_go) state_n = S_ITER;
            S_ITER:  if (cnt == '0) state_n = S_FIX;
            S_FIX:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // One shift-add or restoring-subtract step on the magnitudes
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, m};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Operand capture and iteration; acc is {rem, quotient} for DIV, the product for MUL
    always_ff @(posedge clk) begin
        if (clr) begin
            acc    <= '0;
            m      <= '0;
            a_q    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            cnt    <= '0;
        end else if (seq_go) begin
            is_div <= (op == OP_DIV);
            neg_q  <= Y[WIDTH-1] ^ busMuxOut[WIDTH-1];
            a_q    <= Y;
            m      <= (op == OP_DIV) ? mag_b : mag_a;
            acc    <= (op == OP_DIV) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            cnt    <= SW'(WIDTH - 1);
        end else if (state == S_ITER) begin
            acc <= acc_step;
            cnt <= cnt - SW'(1);
        end
    end

    // Sign fix; a zero divisor yields all-ones quotient and the dividend as remainder
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = a_q[WIDTH-1] ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (m == '0) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = quo;
                fix_hi = rem;
            end
        end
    end
`else
    assign single_go = start;
    assign busy      = 1'b0;
`endif

    // Z registers and done pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            ZHI  <= '0;
            ZLO  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (single_go) begin
                ZLO  <= alu_res;
                ZHI  <= '0;
                done <= 1'b1;
            end
`ifdef DATAPATH_MULDIV_EN
            else if (state == S_FIX) begin
                ZLO  <= fix_lo;
                ZHI  <= fix_hi;
                done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: directed self-checking bench for datapath_param (WIDTH=32, NREGS=16).
// MUL/DIV scenarios are compiled in when DATAPATH_MULDIV_EN is defined.
`timescale 1ns/1ps
module tb_datapath_param;

    localparam int unsigned W = 32;
    localparam int unsigned N = 16;

    logic           clk = 1'b0;
    logic           clr, readMDR, MDRin, reg_in_en, reg_out_en;
    logic [3:0]     reg_in_idx, reg_out_idx, op;
    logic [W-1:0]   mdatain;
    logic           Yin, PCin, HIin, LOin;
    logic           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, start;
    logic           busy, done;
    logic [W-1:0]   busMuxOut, PC, MDR, HI, LO, Y, ZHI, ZLO;
    logic [W*N-1:0] rf_dbg;

    int total = 0;
    int bad   = 0;

    datapath_param #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .clr(clr), .mdatain(mdatain), .readMDR(readMDR), .MDRin(MDRin),
        .reg_in_en(reg_in_en), .reg_in_idx(reg_in_idx),
        .reg_out_en(reg_out_en), .reg_out_idx(reg_out_idx),
        .Yin(Yin), .PCin(PCin), .HIin(HIin), .LOin(LOin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .PCout(PCout), .MDRout(MDRout), .op(op), .start(start),
        .busy(busy), .done(done), .busMuxOut(busMuxOut),
        .PC(PC), .MDR(MDR), .HI(HI), .LO(LO), .Y(Y), .ZHI(ZHI), .ZLO(ZLO),
        .rf_dbg(rf_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        readMDR = 0; MDRin = 0; reg_in_en = 0; reg_out_en = 0;
        reg_in_idx = 0; reg_out_idx = 0; Yin = 0; PCin = 0; HIin = 0; LOin = 0;
        HIout = 0; LOout = 0; ZHIout = 0; ZLOout = 0; PCout = 0; MDRout = 0;
        start = 0; op = 0;
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        mdatain = v; readMDR = 1; MDRin = 1;
        step();
        readMDR = 0; MDRin = 0;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        load_mdr(v);
        MDRout = 1; Yin = 1;
        step();
        MDRout = 0; Yin = 0;
    endtask

    // Y <= a, MDR <= b, then start op with MDR driving the bus
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] opc);
        set_y(a);
        load_mdr(b);
        MDRout = 1; op = opc; start = 1;
        step();
        start = 0; MDRout = 0;
    endtask

    task automatic wait_idle(output int cycles, output int early_done);
        cycles = 0;
        early_done = 0;
        while (busy === 1'b1 && cycles < 100) begin
            if (done !== 1'b0) early_done++;
            cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        idle_ctl();
        mdatain = '0;
        clr = 1;
        step();
        step();
        clr = 0;
        total++; if ({PC, MDR, HI, LO, Y} !== '0) begin bad++; $display("FAIL reset_regs got=%h want=0", {PC, MDR, HI, LO, Y}); end
        total++; if ({ZHI, ZLO} !== '0) begin bad++; $display("FAIL reset_z got=%h want=0", {ZHI, ZLO}); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {busy, done}); end
        total++; if (rf_dbg !== '0) begin bad++; $display("FAIL reset_rf got=%h want=0", rf_dbg); end
        total++; if (busMuxOut !== '0) begin bad++; $display("FAIL reset_bus got=%h want=0", busMuxOut); end
    endtask

    task automatic test_mdr_transfer();
        load_mdr(32'h0000_0012);
        total++; if (MDR !== 32'h12) begin bad++; $display("FAIL mdr_load got=%h want=00000012", MDR); end
        MDRout = 1; reg_in_en = 1; reg_in_idx = 3;
        #1;
        total++; if (busMuxOut !== 32'h12) begin bad++; $display("FAIL mdr_bus got=%h want=00000012", busMuxOut); end
        step();
        MDRout = 0; reg_in_en = 0;
        total++; if (rf_dbg[3*W +: W] !== 32'h12) begin bad++; $display("FAIL r3_write got=%h want=00000012", rf_dbg[3*W +: W]); end
        total++; if (rf_dbg[2*W +: W] !== 32'h0 || rf_dbg[4*W +: W] !== 32'h0) begin
            bad++; $display("FAIL rf_neighbours got=%h/%h want=0/0", rf_dbg[2*W +: W], rf_dbg[4*W +: W]);
        end
        reg_out_en = 1; reg_out_idx = 3;
        #1;
        total++; if (busMuxOut !== 32'h12) begin bad++; $display("FAIL r3_read got=%h want=00000012", busMuxOut); end
        reg_out_en = 0;
    endtask

    task automatic test_bus_priority();
        load_mdr(32'h55);
        MDRout = 1; HIin = 1; PCin = 1;
        step();
        MDRout = 0; HIin = 0; PCin = 0;
        load_mdr(32'h77);
        MDRout = 1; LOin = 1;
        step();
        MDRout = 0; LOin = 0;
        total++; if ({HI, PC, LO} !== {32'h55, 32'h55, 32'h77}) begin bad++; $display("FAIL multi_load got=%h want=000000550000005500000077", {HI, PC, LO}); end
        reg_out_en = 1; reg_out_idx = 3; HIout = 1; MDRout = 1;
        #1;
        total++; if (busMuxOut !== 32'h12) begin bad++; $display("FAIL prio_rf got=%h want=00000012", busMuxOut); end
        reg_out_en = 0; LOout = 1;
        #1;
        total++; if (busMuxOut !== 32'h55) begin bad++; $display("FAIL prio_hi got=%h want=00000055", busMuxOut); end
        HIout = 0; PCout = 1;
        #1;
        total++; if (busMuxOut !== 32'h77) begin bad++; $display("FAIL prio_lo got=%h want=00000077", busMuxOut); end
        LOout = 0;
        #1;
        total++; if (busMuxOut !== 32'h55) begin bad++; $display("FAIL prio_pc got=%h want=00000055", busMuxOut); end
        PCout = 0; MDRout = 0;
        #1;
        total++; if (busMuxOut !== 32'h0) begin bad++; $display("FAIL bus_none got=%h want=0", busMuxOut); end
    endtask

    task automatic test_single_cycle();
        logic [3:0]   vop [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
        logic [W-1:0] va  [12] = '{32'h5, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h0, 32'h3,
                                   32'h80000000, 32'h80000000, 32'h80000001, 32'h1, 32'h1234};
        logic [W-1:0] vb  [12] = '{32'h7, 32'h7, 32'hFF00FF00, 32'hFF00FF00, 32'h0000FFFF, 32'h7, 32'h24,
                                   32'h4, 32'h4, 32'h1, 32'h1, 32'h5678};
        logic [W-1:0] vz  [12] = '{32'hC, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'hFFFF0000, 32'hFFFFFFF9,
                                   32'h30, 32'h08000000, 32'hF8000000, 32'h3, 32'h80000000, 32'h0};
        for (int i = 0; i < 12; i++) begin
            launch(va[i], vb[i], vop[i]);
            total++; if (ZLO !== vz[i] || ZHI !== '0) begin
                bad++; $display("FAIL alu_op%0d got=%h_%h want=00000000_%h", vop[i], ZHI, ZLO, vz[i]);
            end
            total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL alu_flags_op%0d got=%b want=01", vop[i], {busy, done}); end
        end
        launch(32'h5, 32'h7, 4'd0);
        ZLOout = 1; PCout = 1;
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
        total++; if (busMuxOut !== 32'hC) begin bad++; $display("FAIL prio_zlo got=%h want=0000000C", busMuxOut); end
        ZLOout = 0; PCout = 0;
    endtask

    task automatic test_clr_dominates();
        set_y(32'h5);
        load_mdr(32'h7);
        MDRout = 1; op = 4'd0; start = 1; Yin = 1; PCin = 1; clr = 1;
        step();
        MDRout = 0; start = 0; Yin = 0; PCin = 0; clr = 0;
        total++; if ({ZHI, ZLO, done} !== '0) begin bad++; $display("FAIL clr_start got=%h_%h done=%b want=0_0 done=0", ZHI, ZLO, done); end
        total++; if ({Y, PC, MDR, HI, LO} !== '0) begin bad++; $display("FAIL clr_loads got=%h want=0", {Y, PC, MDR, HI, LO}); end
        total++; if (rf_dbg !== '0) begin bad++; $display("FAIL clr_rf got=%h want=0", rf_dbg); end
    endtask

`ifdef DATAPATH_MULDIV_EN
    task automatic test_muldiv();
        int c, e;
        launch(32'hFFFFFFFD, 32'h7, 4'd11);
        op = 4'd0;
        wait_idle(c, e);
        total++; if (c != W + 1 || e != 0) begin bad++; $display("FAIL mul_busy got=%0d early_done=%0d want=%0d/0", c, e, W + 1); end
        total++; if ({ZHI, ZLO} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mul_result got=%h_%h want=ffffffff_ffffffeb", ZHI, ZLO); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mul_done got=%b want=1", done); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b want=0", done); end
        launch(32'hFFFFFFF9, 32'h2, 4'd12);
        wait_idle(c, e);
        total++; if ({ZHI, ZLO} !== 64'hFFFFFFFF_FFFFFFFD || done !== 1'b1 || c != W + 1) begin
            bad++; $display("FAIL div_neg got=%h_%h done=%b cyc=%0d want=ffffffff_fffffffd done=1 cyc=%0d", ZHI, ZLO, done, c, W + 1);
        end
    endtask

    task automatic test_clr_midop();
        int dcount = 0;
        launch(32'hFFFFFFFD, 32'h7, 4'd11);
        for (int i = 0; i < 9; i++) step();
        clr = 1;
        step();
        clr = 0;
        total++; if ({busy, done} !== 2'b00 || {ZHI, ZLO} !== '0) begin
            bad++; $display("FAIL clr_midop got=busy%b done%b z=%h_%h want=busy0 done0 z=0_0", busy, done, ZHI, ZLO);
        end
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dcount++;
            step();
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL clr_no_done got=%0d want=0", dcount); end
    endtask

    task automatic test_back_to_back();
        int c, e;
        launch(32'h9, 32'h0, 4'd12);
        for (int i = 0; i < 3; i++) step();
        op = 4'd0; start = 1;
        step();
        start = 0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || {ZHI, ZLO} !== '0) begin
            bad++; $display("FAIL start_ignored got=busy%b done%b z=%h_%h want=busy1 done0 z=0_0", busy, done, ZHI, ZLO);
        end
        wait_idle(c, e);
        total++; if (c + 4 != W + 1 || e != 0) begin bad++; $display("FAIL div0_busy got=%0d early=%0d want=%0d/0", c + 4, e, W + 1); end
        total++; if ({ZHI, ZLO} !== 64'h00000009_FFFFFFFF || done !== 1'b1) begin
            bad++; $display("FAIL div_zero got=%h_%h done=%b want=00000009_ffffffff done=1", ZHI, ZLO, done);
        end
        MDRout = 1; op = 4'd11; start = 1;
        step();
        start = 0; MDRout = 0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b want=10", {busy, done}); end
        wait_idle(c, e);
        total++; if (c + 1 != W + 1 || {ZHI, ZLO} !== '0 || done !== 1'b1) begin
            bad++; $display("FAIL b2b_mul got=cyc%0d z=%h_%h done=%b want=cyc%0d z=0_0 done=1", c + 1, ZHI, ZLO, done, W + 1);
        end
    endtask
`else
    task automatic test_undef_seq();
        launch(32'h5, 32'h7, 4'd0);
        launch(32'hFFFFFFFD, 32'h7, 4'd11);
        total++; if ({ZHI, ZLO} !== '0 || {busy, done} !== 2'b01) begin
            bad++; $display("FAIL mul_disabled got=%h_%h busy%b done%b want=0_0 busy0 done1", ZHI, ZLO, busy, done);
        end
        launch(32'h5, 32'h7, 4'd0);
        launch(32'hFFFFFFF9, 32'h2, 4'd12);
        total++; if ({ZHI, ZLO} !== '0 || {busy, done} !== 2'b01) begin
            bad++; $display("FAIL div_disabled got=%h_%h busy%b done%b want=0_0 busy0 done1", ZHI, ZLO, busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mdr_transfer();
        test_bus_priority();
        test_single_cycle();
        test_clr_dominates();
`ifdef DATAPATH_MULDIV_EN
        test_muldiv();
        test_clr_midop();
        test_back_to_back();
`else
        test_undef_seq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
